// File: rtl/alu_b_if.sv
// alu_b_if: operand, opcode, result and flag bundle for the execute-stage ALU
interface alu_b_if;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] ALU_Sel;
   logic [7:0] Result;
   logic [3:0] NZVC;
   modport master (output A, B, ALU_Sel, input Result, NZVC);
   modport slave (input A, B, ALU_Sel, output Result, NZVC);
endinterface

// File: rtl/alu_b.sv
// alu_b: 8-bit 8-function ALU with registered result and {N,Z,V,C} flags
module alu_b (
   input logic    clk,
   input logic    rst_n,
   alu_b_if.slave bus
);
   logic [7:0] w_b;
   logic [7:0] w_sum;
   logic [7:0] w_res;
   logic [8:0] w_c;
   logic       w_arith;
   logic       w_sub;
   logic       w_v;
   logic       w_cf;
   logic [7:0] r_result;
   logic [3:0] r_nzvc;
   assign w_arith = ~bus.ALU_Sel[2];
   assign w_sub   = bus.ALU_Sel[1];
   // SUB uses ~B with carry-in 1; DEC adds ~1 with carry-in 1; INC adds 0 with carry-in 1
   assign w_b    = bus.ALU_Sel[0] ? (w_sub ? 8'hFE : 8'h00) : (w_sub ? ~bus.B : bus.B);
   assign w_c[0] = |bus.ALU_Sel[1:0];
   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign w_sum[i]   = bus.A[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1]   = (bus.A[i] & w_b[i]) | (w_c[i] & (bus.A[i] ^ w_b[i]));
   end
   // result mux and overflow/carry; borrow is the inverted carry-out for SUB/DEC
   always_comb begin
      w_res = w_arith ? w_sum :
              bus.ALU_Sel[1:0] == 2'd0 ? bus.A & bus.B :
              bus.ALU_Sel[1:0] == 2'd1 ? bus.A | bus.B :
              bus.ALU_Sel[1:0] == 2'd2 ? bus.A ^ bus.B : ~bus.A;
      w_v   = w_arith & (bus.A[7] == w_b[7]) & (w_sum[7] != bus.A[7]);
      w_cf  = w_arith & (w_c[8] ^ w_sub);
   end
   // output register bank, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= 8'h00;
         r_nzvc   <= 4'b0000;
      end else begin
         r_result <= w_res;
         r_nzvc   <= {w_res[7], w_res == 8'h00, w_v, w_cf};
      end
   end
   assign bus.Result = r_result;
   assign bus.NZVC   = r_nzvc;
endmodule

// File: tb/tb_alu_b.sv
// tb_alu_b: directed and randomized checking of alu_b against an arithmetic model
module tb_alu_b;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   alu_b_if bus ();
   alu_b dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got NZVC=%b Result=%h, expected NZVC=%b Result=%h",
                  tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
   endtask

   function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int unsigned ua = a;
      int unsigned ub = b;
      logic [7:0] r = 8'h00;
      logic v = 1'b0;
      logic c = 1'b0;
      case (op)
         3'd0: begin r = 8'(ua + ub); c = (ua + ub) > 255; v = (a[7] == b[7]) && (r[7] != a[7]); end
         3'd1: begin r = 8'(ua + 1); c = (a == 8'hFF); v = (a == 8'h7F); end
         3'd2: begin r = 8'(ua - ub); c = ua < ub; v = (a[7] != b[7]) && (r[7] != a[7]); end
         3'd3: begin r = 8'(ua - 1); c = (a == 8'h00); v = (a == 8'h80); end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
      return {r[7], r == 8'h00, v, c, r};
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.A = a;
      bus.B = b;
      bus.ALU_Sel = op;
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [11:0] exp; } vec_t;
   vec_t vecs[11] = '{
      '{8'h64, 8'h1E, 3'd0, 12'hA82}, '{8'h64, 8'h88, 3'd0, 12'h8EC},
      '{8'h7F, 8'h00, 3'd1, 12'hA80}, '{8'hFF, 8'h00, 3'd1, 12'h500},
      '{8'h11, 8'h28, 3'd2, 12'h9E9}, '{8'h49, 8'hA3, 3'd2, 12'hBA6},
      '{8'h80, 8'h00, 3'd3, 12'h27F}, '{8'h01, 8'h00, 3'd3, 12'h400},
      '{8'h4E, 8'h79, 3'd4, 12'h048}, '{8'h00, 8'hFF, 3'd6, 12'h8FF},
      '{8'hFF, 8'h00, 3'd7, 12'h400}};

   initial begin
      logic [7:0] a, b;
      logic [2:0] op;
      bus.A = 8'h5A;
      bus.B = 8'hC3;
      bus.ALU_Sel = 3'd0;
      #2 chk("reset_initial", {bus.NZVC, bus.Result}, 12'h000);
      @(posedge clk);
      #1 chk("reset_held_edge", {bus.NZVC, bus.Result}, 12'h000);
      rst_n = 1'b1;
      foreach (vecs[k]) begin
         drive(vecs[k].a, vecs[k].b, vecs[k].op);
         chk($sformatf("dir%0d_op%0d", k, vecs[k].op), {bus.NZVC, bus.Result}, vecs[k].exp);
      end
      drive(8'h64, 8'h1E, 3'd0);
      chk("pre_async_reset", {bus.NZVC, bus.Result}, 12'hA82);
      bus.A = 8'hFF;
      bus.ALU_Sel = 3'd1;
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {bus.NZVC, bus.Result}, 12'h000);
      @(posedge clk);
      #1 chk("async_reset_held", {bus.NZVC, bus.Result}, 12'h000);
      rst_n = 1'b1;
      #2 chk("reset_release_no_edge", {bus.NZVC, bus.Result}, 12'h000);
      @(posedge clk);
      #1 chk("first_after_reset", {bus.NZVC, bus.Result}, 12'h500);
      for (int n = 0; n < 30000; n++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         op = 3'($urandom);
         if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? 8'h00 : 8'hFF;
         if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? 8'h7F : 8'h80;
         drive(a, b, op);
         chk($sformatf("rand_op%0d_a%h_b%h", op, a, b), {bus.NZVC, bus.Result}, model(a, b, op));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
